// File: rtl/matrix_if_pkg.sv
// matrix_if_pkg: shared types and widths for the matrix calculator pin-interface driver
package matrix_if_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, SETUP, PULSE, GAP, WAIT_FIN, DONE, FAIL} drv_state_t;
  localparam logic [1:0] FAIL_NONE    = 2'b00;
  localparam logic [1:0] FAIL_CALC    = 2'b01;
  localparam logic [1:0] FAIL_TIMEOUT = 2'b10;
  localparam int DATA_W = 8;
  localparam int RES_W  = 5;
  localparam int IDX_W  = 4;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/synchronizer.sv
// synchronizer: 2-flop synchronizer for one asynchronous input bit
module synchronizer (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta, r_q;
  always_ff @(posedge clk)
    if (rst) {r_meta, r_q} <= 2'b00;
    else {r_meta, r_q} <= {i_d, r_meta};
  assign o_q = r_q;
endmodule

// File: rtl/matrix_entry_driver.sv
// matrix_entry_driver: paces operand bytes onto the calculator pins and reports its results
module matrix_entry_driver
  import matrix_if_pkg::*;
#(
  parameter int N_ENTRIES   = 8,
  parameter int SETUP_CYC   = 4,
  parameter int PULSE_CYC   = 8,
  parameter int GAP_CYC     = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op_sel,
  input  logic              entry_valid,
  input  logic [DATA_W-1:0] entry_data,
  output logic              entry_ready,
  output logic [DATA_W-1:0] calc_data_in,
  output logic              calc_enter,
  output logic [1:0]        calc_operation,
  input  logic [RES_W-1:0]  calc_data_out,
  input  logic [IDX_W-1:0]  calc_index,
  input  logic              calc_finish,
  input  logic              calc_error,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic              result_valid,
  output logic [RES_W-1:0]  result_data,
  output logic [IDX_W-1:0]  result_index
);
  localparam int PH_W  = $clog2(max3(SETUP_CYC, PULSE_CYC, GAP_CYC) + 1);
  localparam int CNT_W = $clog2(N_ENTRIES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SYN_W = RES_W + IDX_W + 2;
  logic [SYN_W-1:0] w_async, w_sync;
  logic [RES_W-1:0] w_res;
  logic [IDX_W-1:0] w_idx;
  logic             w_finish, w_error;
  assign w_async = {calc_data_out, calc_index, calc_finish, calc_error};
  assign {w_res, w_idx, w_finish, w_error} = w_sync;
  for (genvar i = 0; i < SYN_W; i++) begin : g_sync
    synchronizer u_sync (.clk(clk), .rst(rst), .i_d(w_async[i]), .o_q(w_sync[i]));
  end
  drv_state_t       r_state, w_next;
  logic [PH_W-1:0]  r_phase;
  logic [CNT_W-1:0] r_count;
  logic [TMO_W-1:0] r_tmo;
  logic [DATA_W-1:0] r_data;
  logic [1:0]       r_op, r_fcode;
  logic             r_rvalid;
  logic [RES_W-1:0] r_rdata;
  logic [IDX_W-1:0] r_ridx, r_idx_prev;
  logic             w_busy, w_start_ok, w_phase_end, w_strobe;
  assign w_busy      = !(r_state inside {IDLE, DONE, FAIL});
  assign w_start_ok  = start && !w_busy;
  assign w_phase_end = (r_state == SETUP) ? (r_phase == PH_W'(SETUP_CYC - 1)) :
                       (r_state == PULSE) ? (r_phase == PH_W'(PULSE_CYC - 1)) :
                                            (r_phase == PH_W'(GAP_CYC - 1));
  // a strobe on entering DONE, then one per index step while DONE persists
  assign w_strobe    = (w_next == DONE) && (r_state == WAIT_FIN || w_idx != r_idx_prev);
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_busy && w_error) w_next = FAIL;
    else case (r_state)
      IDLE, DONE, FAIL: w_next = start ? LOAD : r_state;
      LOAD:     w_next = entry_valid ? SETUP : LOAD;
      SETUP:    w_next = w_phase_end ? PULSE : SETUP;
      PULSE:    w_next = w_phase_end ? GAP : PULSE;
      GAP:      w_next = !w_phase_end ? GAP : (r_count == CNT_W'(N_ENTRIES - 1)) ? WAIT_FIN : LOAD;
      WAIT_FIN: w_next = w_finish ? DONE : (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) ? FAIL : WAIT_FIN;
      default:  w_next = IDLE;
    endcase
  end
  always_comb begin
    entry_ready = r_state == LOAD;
    calc_enter  = r_state == PULSE;
    busy        = w_busy;
    done        = r_state == DONE;
    fail        = r_state == FAIL;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase    <= '0;
      r_count    <= '0;
      r_tmo      <= '0;
      r_data     <= '0;
      r_op       <= '0;
      r_fcode    <= FAIL_NONE;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_ridx     <= '0;
      r_idx_prev <= '0;
    end else begin
      r_phase    <= (w_next == r_state && r_state inside {SETUP, PULSE, GAP}) ? r_phase + 1'b1 : '0;
      r_tmo      <= (r_state == WAIT_FIN) ? r_tmo + 1'b1 : '0;
      r_count    <= w_start_ok ? '0 : (r_state == GAP && w_phase_end) ? r_count + 1'b1 : r_count;
      r_op       <= w_start_ok ? op_sel : r_op;
      r_data     <= (r_state == LOAD && w_next == SETUP) ? entry_data : r_data;
      r_fcode    <= w_start_ok ? FAIL_NONE :
                    (w_busy && w_error) ? FAIL_CALC :
                    (r_state == WAIT_FIN && w_next == FAIL) ? FAIL_TIMEOUT : r_fcode;
      r_rvalid   <= w_strobe;
      r_rdata    <= w_strobe ? w_res : r_rdata;
      r_ridx     <= w_strobe ? w_idx : r_ridx;
      r_idx_prev <= w_idx;
    end
  end
  assign calc_data_in   = r_data;
  assign calc_operation = r_op;
  assign fail_code      = r_fcode;
  assign result_valid   = r_rvalid;
  assign result_data    = r_rdata;
  assign result_index   = r_ridx;
endmodule

// File: tb/tb_matrix_entry_driver.sv
// tb_matrix_entry_driver: directed stimulus with a timeline-level reference model of the driver
module tb_matrix_entry_driver;
  localparam int S = 4, P = 8, G = 8, N = 8, T = 1024;
  localparam int M_IDLE = 0, M_LOAD = 1, M_SHAPE = 2, M_WAIT = 3, M_DONE = 4, M_FAIL = 5;
  logic clk, rst, start, entry_valid, entry_ready, calc_enter, calc_finish, calc_error;
  logic busy, done, fail, result_valid;
  logic [1:0] op_sel, calc_operation, fail_code;
  logic [7:0] entry_data, calc_data_in;
  logic [4:0] calc_data_out, result_data;
  logic [3:0] calc_index, result_index;
  matrix_entry_driver dut (
    .clk(clk), .rst(rst), .start(start), .op_sel(op_sel), .entry_valid(entry_valid),
    .entry_data(entry_data), .entry_ready(entry_ready), .calc_data_in(calc_data_in),
    .calc_enter(calc_enter), .calc_operation(calc_operation), .calc_data_out(calc_data_out),
    .calc_index(calc_index), .calc_finish(calc_finish), .calc_error(calc_error),
    .busy(busy), .done(done), .fail(fail), .fail_code(fail_code), .result_valid(result_valid),
    .result_data(result_data), .result_index(result_index)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  int checks = 0, errors = 0;
  bit chk_en = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask
  // reference model: one timeline per byte instead of separate setup/pulse/gap phases
  int m_mode = M_IDLE, m_t = 0, m_n = 0, m_w = 0;
  logic [7:0] m_data = '0;
  logic [1:0] m_op = '0, m_fc = '0;
  logic m_rv = 1'b0;
  logic [4:0] m_rd = '0, d2;
  logic [3:0] m_ri = '0, m_iprev = '0, i2;
  logic f2, e2;
  logic [10:0] p1 = '0, p2 = '0;
  bit m_busy;
  always @(posedge clk) begin
    {d2, i2, f2, e2} = p2;
    if (rst) begin
      m_mode = M_IDLE; m_t = 0; m_n = 0; m_w = 0; m_data = '0; m_op = '0; m_fc = '0;
      m_rv = 1'b0; m_rd = '0; m_ri = '0; m_iprev = '0; p1 = '0; p2 = '0;
    end else begin
      m_busy = m_mode inside {M_LOAD, M_SHAPE, M_WAIT};
      m_rv = 1'b0;
      if (m_busy && e2) begin
        m_mode = M_FAIL; m_fc = 2'b01;
      end else if (!m_busy && start) begin
        m_mode = M_LOAD; m_op = op_sel; m_fc = 2'b00; m_n = 0;
      end else case (m_mode)
        M_LOAD: if (entry_valid) begin m_data = entry_data; m_mode = M_SHAPE; m_t = 0; end
        M_SHAPE: if (m_t == S + P + G - 1) begin
            m_n++; m_mode = (m_n == N) ? M_WAIT : M_LOAD; m_w = 0;
          end else m_t++;
        M_WAIT: if (f2) begin
            m_mode = M_DONE; m_rv = 1'b1; m_rd = d2; m_ri = i2;
          end else if (m_w == T - 1) begin
            m_mode = M_FAIL; m_fc = 2'b10;
          end else m_w++;
        M_DONE: if (i2 != m_iprev) begin m_rv = 1'b1; m_rd = d2; m_ri = i2; end
        default: ;
      endcase
      m_iprev = i2;
      p2 = p1;
      p1 = {calc_data_out, calc_index, calc_finish, calc_error};
    end
  end
  logic [26:0] outv, expv;
  assign outv = {entry_ready, calc_data_in, calc_enter, calc_operation, busy, done, fail,
                 fail_code, result_valid, result_data, result_index};
  assign expv = {m_mode == M_LOAD, m_data, m_mode == M_SHAPE && m_t >= S && m_t < S + P, m_op,
                 m_mode inside {M_LOAD, M_SHAPE, M_WAIT}, m_mode == M_DONE, m_mode == M_FAIL,
                 m_fc, m_rv, m_rd, m_ri};
  always @(negedge clk)
    if (chk_en) chk("outputs_vs_model", 32'(outv), 32'(expv));
  // pin-level monitor: pulse counting, widths, data setup age, result strobes
  int cyc = 0, age = 0, n_rise = 0, n_fall = 0, n_strobe = 0, rise_cyc = 0, fall_cyc = 0;
  logic [7:0] prev_d = '0;
  logic prev_e = 1'b0;
  logic [1:0] exp_op = '0;
  logic [4:0] s_d = '0;
  logic [3:0] s_i = '0;
  always @(negedge clk) begin
    cyc++;
    if (calc_data_in !== prev_d) age = 0; else age++;
    prev_d = calc_data_in;
    if (calc_enter === 1'b1 && prev_e !== 1'b1) begin
      n_rise++; rise_cyc = cyc;
      if (chk_en) begin
        chk("setup_age", age, 4);
        chk("op_at_rise", 32'(calc_operation), 32'(exp_op));
      end
    end
    if (calc_enter === 1'b0 && prev_e === 1'b1) begin
      n_fall++; fall_cyc = cyc;
      if (m_mode == M_SHAPE) chk("pulse_width", cyc - rise_cyc, P);
    end
    prev_e = calc_enter;
    if (result_valid === 1'b1) begin n_strobe++; s_d = result_data; s_i = result_index; end
  end
  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  function automatic int cur(input int which);
    case (which)
      0: return n_rise;
      1: return n_fall;
      2: return n_strobe;
      default: return (fail === 1'b1) ? 1 : 0;
    endcase
  endfunction
  task automatic wait_until(input string name, input int which, input int k);
    for (int i = 0; i < 1500 && cur(which) < k; i++) tick(1);
    chk(name, 32'(cur(which) >= k), 1);
  endtask
  task automatic do_start(input logic [1:0] op);
    op_sel = op; exp_op = op; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b);
    entry_valid = 1'b1; entry_data = b;
    for (int i = 0; i < 200 && entry_ready !== 1'b1; i++) tick(1);
    if (entry_ready !== 1'b1) chk("ready_wait", 0, 1);
    tick(1);
    entry_valid = 1'b0;
  endtask
  int base, r4, k;
  initial begin
    rst = 1'b1; start = 1'b0; op_sel = '0; entry_valid = 1'b0; entry_data = '0;
    calc_data_out = 5'h13; calc_index = '0; calc_finish = 1'b0; calc_error = 1'b0;
    tick(3);
    chk_en = 1;
    chk("reset_outputs", 32'(outv), 0);
    rst = 1'b0;
    tick(2);
    // eight bytes, then the calculator finishes 50 cycles after the last pulse
    base = n_rise;
    do_start(2'b10);
    for (int b = 1; b <= 8; b++) send_byte(8'(b));
    wait_until("wait_8th_fall", 1, base + 8);
    chk("pulse_count", n_rise - base, 8);
    chk("op_held", 32'(calc_operation), 2);
    tick(50);
    calc_finish = 1'b1;
    wait_until("wait_strobe1", 2, 1);
    chk("done_level", 32'(done), 1);
    chk("res1_data", 32'(s_d), 32'h13);
    chk("res1_idx", 32'(s_i), 0);
    calc_index = 4'd1; calc_data_out = 5'h07;
    wait_until("wait_strobe2", 2, 2);
    chk("res2_data", 32'(s_d), 32'h07);
    chk("res2_idx", 32'(s_i), 1);
    tick(3);
    chk("strobe_count", n_strobe, 2);
    calc_finish = 1'b0;
    // restart from DONE, starve upstream before byte 5, then let the finish timeout expire
    base = n_rise;
    do_start(2'b01);
    for (int b = 1; b <= 4; b++) send_byte(8'(b));
    wait_until("wait_4th_fall", 1, n_fall + 1);
    tick(10);
    r4 = n_rise;
    tick(100);
    chk("starved_no_pulse", n_rise - r4, 0);
    chk("starved_ready", 32'(entry_ready), 1);
    for (int b = 5; b <= 8; b++) send_byte(8'(b));
    wait_until("wait_8th_fall_b", 0, base + 8);
    wait_until("wait_8th_fall_c", 1, n_fall + ((calc_enter === 1'b1) ? 1 : 0));
    wait_until("wait_timeout", 3, 1);
    chk("timeout_cycles", cyc - fall_cyc, G + T);
    chk("timeout_code", 32'(fail_code), 2);
    // calculator error in the middle of the 3rd pulse
    base = n_rise;
    do_start(2'b11);
    chk("fail_code_cleared", 32'(fail_code), 0);
    for (int b = 1; b <= 3; b++) send_byte(8'(b));
    wait_until("wait_3rd_rise", 0, base + 3);
    tick(1);
    calc_error = 1'b1;
    for (k = 1; k <= 6; k++) begin
      tick(1);
      calc_error = 1'b0;
      if (calc_enter === 1'b0) break;
    end
    chk("enter_drop_cycles", k, 3);
    chk("err_fail", 32'(fail), 1);
    chk("err_code", 32'(fail_code), 1);
    // error and finish together while waiting: error wins
    base = n_rise;
    do_start(2'b00);
    for (int b = 1; b <= 8; b++) send_byte(8'(b));
    wait_until("wait_8th_rise_d", 0, base + 8);
    tick(30);
    calc_error = 1'b1; calc_finish = 1'b1;
    tick(1);
    calc_error = 1'b0; calc_finish = 1'b0;
    tick(5);
    chk("both_fail", 32'(fail), 1);
    chk("both_done", 32'(done), 0);
    chk("both_code", 32'(fail_code), 1);
    // reset mid-pulse, then a start while busy must be ignored
    base = n_rise;
    do_start(2'b10);
    send_byte(8'hAA);
    wait_until("wait_rise_e", 0, base + 1);
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("midpulse_reset_outputs", 32'(outv), 0);
    rst = 1'b0;
    tick(1);
    do_start(2'b01);
    send_byte(8'h55);
    tick(1);
    op_sel = 2'b11; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("busy_start_op", 32'(calc_operation), 1);
    chk("busy_start_busy", 32'(busy), 1);
    chk("busy_start_data", 32'(calc_data_in), 32'h55);
    tick(10);
    chk("busy_start_op_later", 32'(calc_operation), 1);
    tick(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
